// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: display-end model of an 8-bit HD44780-style bus with a 2x16 DDRAM,
// address counter, busy timer and a registered side read port.
module lcd_bus_responder #(
   parameter int BUSY_SHORT = 2000,
   parameter int BUSY_LONG  = 82000
) (
   input  logic       clock50MHz,
   input  logic       reset,
   input  logic       RS,
   input  logic       RW,
   input  logic       E,
   input  logic [7:0] DB,
   output logic [7:0] DB_out,
   output logic       DB_oe,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       busy,
   output logic [6:0] ac,
   output logic       display_on,
   output logic       cursor_on,
   output logic       blink_on,
   output logic       err
);
   localparam int CW = $clog2(BUSY_LONG + 1);
   localparam logic [0:0] IDLE = 1'b0, CLEAR = 1'b1;
   logic          e_s1, e_s2, e_d, rs_s1, rs_s2, rw_s1, rw_s2;
   logic [7:0]    db_s1, db_s2;
   logic [0:0]    state;
   logic [4:0]    fill;
   logic [CW-1:0] cnt;
   logic          inc, fall, long_ins;
   logic [4:0]    idx;
   logic [7:0]    mem [32];
   function automatic logic [6:0] step(input logic [6:0] a, input logic up);
      step = up ? (a == 7'h0F ? 7'h40 : a == 7'h4F ? 7'h00 : a + 7'd1)
                : (a == 7'h00 ? 7'h4F : a == 7'h40 ? 7'h0F : a - 7'd1);
   endfunction
   assign idx      = {ac[6], ac[3:0]};
   assign fall     = e_d & ~e_s2;
   assign busy     = cnt != '0;
   assign DB_oe    = e_s2 & rw_s2;
   assign DB_out   = DB_oe ? (rs_s2 ? mem[idx] : {busy, ac}) : 8'h00;
   assign long_ins = db_s2[7:2] == 6'd0 && db_s2[1:0] != 2'd0;
   always_ff @(posedge clock50MHz or negedge reset)
      if (!reset) begin
         {e_s1, e_s2, e_d, rs_s1, rs_s2, rw_s1, rw_s2} <= '0;
         db_s1      <= '0;
         db_s2      <= '0;
         state      <= IDLE;
         fill       <= '0;
         cnt        <= '0;
         inc        <= 1'b1;
         ac         <= '0;
         display_on <= 1'b0;
         cursor_on  <= 1'b0;
         blink_on   <= 1'b0;
         err        <= 1'b0;
         rd_data    <= '0;
         for (int i = 0; i < 32; i++) mem[i] <= 8'h20;
      end else begin
         {e_s1, e_s2, e_d} <= {E, e_s1, e_s2};
         {rs_s1, rs_s2}    <= {RS, rs_s1};
         {rw_s1, rw_s2}    <= {RW, rw_s1};
         {db_s1, db_s2}    <= {DB, db_s1};
         rd_data           <= mem[rd_addr];
         if (busy) cnt <= cnt - CW'(1);
         if (fall) begin
            if (rw_s2) begin
               if (rs_s2) ac <= step(ac, inc);
            end else if (busy) begin
               err <= 1'b1;
            end else if (rs_s2) begin
               mem[idx] <= db_s2;
               ac       <= step(ac, inc);
               cnt      <= CW'(BUSY_SHORT);
            end else begin
               cnt <= db_s2 == 8'h00 ? '0 : long_ins ? CW'(BUSY_LONG) : CW'(BUSY_SHORT);
               if (db_s2[7]) begin
                  ac  <= db_s2[5:4] == 2'b00 ? db_s2[6:0] : ac;
                  err <= err | (db_s2[5:4] != 2'b00);
               end else if (!db_s2[6]) begin
                  if (db_s2[5]) err <= err | ~db_s2[4];
                  else if (db_s2[4]) ac <= db_s2[3] ? ac : step(ac, db_s2[2]);
                  else if (db_s2[3]) {display_on, cursor_on, blink_on} <= db_s2[2:0];
                  else if (db_s2[2]) inc <= db_s2[1];
                  else if (db_s2[1]) ac <= '0;
                  else if (db_s2[0]) begin
                     state <= CLEAR;
                     fill  <= '0;
                  end
               end
            end
         end
         // fill completion takes precedence over any read-driven ac step in the same cycle
         if (state == CLEAR) begin
            mem[fill] <= 8'h20;
            fill      <= fill + 5'd1;
            if (fill == 5'd31) begin
               state <= IDLE;
               ac    <= '0;
               inc   <= 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb_lcd_bus_responder: directed vector table plus hand sequences for clear, errors and reset.
module tb_lcd_bus_responder;
   localparam int BS = 20, BL = 100;
   logic       clk = 1'b0, reset = 1'b0, RS = 1'b0, RW = 1'b0, E = 1'b0;
   logic [7:0] DB = 8'h00, DB_out, rd_data, d;
   logic       DB_oe, busy, display_on, cursor_on, blink_on, err, oe;
   logic [4:0] rd_addr = 5'd0;
   logic [6:0] ac;
   int         total = 0, bad = 0, n;
   typedef struct packed {
      logic       rs;
      logic [7:0] db;
      logic [6:0] ac;
      logic [4:0] ri;
      logic [7:0] rv;
   } vec_t;
   vec_t tbl [17];

   lcd_bus_responder #(.BUSY_SHORT(BS), .BUSY_LONG(BL)) dut (
      .clock50MHz(clk), .reset(reset), .RS(RS), .RW(RW), .E(E), .DB(DB),
      .DB_out(DB_out), .DB_oe(DB_oe), .rd_addr(rd_addr), .rd_data(rd_data),
      .busy(busy), .ac(ac), .display_on(display_on), .cursor_on(cursor_on),
      .blink_on(blink_on), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic bus_op(input logic rs, input logic rw, input logic [7:0] v);
      RS = rs; RW = rw; DB = v; E = 1'b1;
      repeat (4) @(negedge clk);
      E = 1'b0;
      repeat (4) @(negedge clk);
      RW = 1'b0;
   endtask

   task automatic read_op(input logic rs, output logic [7:0] v, output logic o);
      RS = rs; RW = 1'b1; E = 1'b1;
      repeat (3) @(negedge clk);
      v = DB_out;
      o = DB_oe;
      @(negedge clk);
      E = 1'b0;
      repeat (4) @(negedge clk);
      RW = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 1000) begin
         @(negedge clk);
         k++;
      end
      if (busy) chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic rd_chk(input string name, input logic [4:0] a, input logic [7:0] v);
      rd_addr = a;
      repeat (2) @(negedge clk);
      chk(name, 32'(rd_data), 32'(v));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      tbl[0]  = '{1'b0, 8'h38, 7'h00, 5'd0,  8'h20};
      tbl[1]  = '{1'b0, 8'h0C, 7'h00, 5'd0,  8'h20};
      tbl[2]  = '{1'b0, 8'h06, 7'h00, 5'd0,  8'h20};
      tbl[3]  = '{1'b1, 8'h41, 7'h01, 5'd0,  8'h41};
      tbl[4]  = '{1'b0, 8'h8F, 7'h0F, 5'd15, 8'h20};
      tbl[5]  = '{1'b1, 8'h42, 7'h40, 5'd15, 8'h42};
      tbl[6]  = '{1'b1, 8'h43, 7'h41, 5'd16, 8'h43};
      tbl[7]  = '{1'b0, 8'hC0, 7'h40, 5'd0,  8'h41};
      tbl[8]  = '{1'b0, 8'h04, 7'h40, 5'd16, 8'h43};
      tbl[9]  = '{1'b1, 8'h44, 7'h0F, 5'd16, 8'h44};
      tbl[10] = '{1'b0, 8'h80, 7'h00, 5'd15, 8'h42};
      tbl[11] = '{1'b1, 8'h45, 7'h4F, 5'd0,  8'h45};
      tbl[12] = '{1'b0, 8'h14, 7'h00, 5'd31, 8'h20};
      tbl[13] = '{1'b0, 8'h10, 7'h4F, 5'd1,  8'h20};
      tbl[14] = '{1'b0, 8'h18, 7'h4F, 5'd0,  8'h45};
      tbl[15] = '{1'b0, 8'h06, 7'h4F, 5'd16, 8'h44};
      tbl[16] = '{1'b0, 8'h40, 7'h4F, 5'd15, 8'h42};

      #2;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ac", 32'(ac), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_oe", 32'(DB_oe), 0);
      chk("rst_dbout", 32'(DB_out), 0);
      chk("rst_rd", 32'(rd_data), 0);
      chk("rst_disp", 32'({display_on, cursor_on, blink_on}), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 17; i++) begin
         bus_op(tbl[i].rs, 1'b0, tbl[i].db);
         chk($sformatf("v%0d_ac", i), 32'(ac), 32'(tbl[i].ac));
         chk($sformatf("v%0d_busy", i), 32'(busy), 1);
         chk($sformatf("v%0d_err", i), 32'(err), 0);
         rd_chk($sformatf("v%0d_rd", i), tbl[i].ri, tbl[i].rv);
         wait_idle();
      end
      chk("disp_bits", 32'({display_on, cursor_on, blink_on}), 32'h4);

      read_op(1'b0, d, oe);
      chk("rd_status", 32'(d), 32'h4F);
      chk("rd_status_oe", 32'(oe), 1);
      chk("rd_status_ac", 32'(ac), 32'h4F);
      chk("oe_low", 32'(DB_oe), 0);
      bus_op(1'b0, 1'b0, 8'h80);
      wait_idle();
      read_op(1'b1, d, oe);
      chk("rd_data", 32'(d), 32'h45);
      chk("rd_data_oe", 32'(oe), 1);
      chk("rd_data_ac", 32'(ac), 32'h01);
      chk("rd_data_nobusy", 32'(busy), 0);

      bus_op(1'b0, 1'b0, 8'h01);
      chk("clr_busy", 32'(busy), 1);
      read_op(1'b0, d, oe);
      chk("clr_mid_bf", 32'(d[7]), 1);
      n = 0;
      while (busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("clr_busy_len", n, BL - 9);
      chk("clr_ac", 32'(ac), 0);
      for (int i = 0; i < 32; i++) rd_chk($sformatf("clr_m%0d", i), 5'(i), 8'h20);

      bus_op(1'b0, 1'b0, 8'h85);
      wait_idle();
      bus_op(1'b0, 1'b0, 8'h95);
      chk("badaddr_err", 32'(err), 1);
      chk("badaddr_ac", 32'(ac), 32'h05);
      wait_idle();
      do_reset();
      chk("err_cleared", 32'(err), 0);
      bus_op(1'b0, 1'b0, 8'h28);
      chk("fset4_err", 32'(err), 1);
      wait_idle();
      do_reset();

      bus_op(1'b1, 1'b0, 8'h50);
      bus_op(1'b1, 1'b0, 8'h51);
      chk("wbusy_err", 32'(err), 1);
      chk("wbusy_ac", 32'(ac), 32'h01);
      rd_chk("wbusy_m0", 5'd0, 8'h50);
      rd_chk("wbusy_m1", 5'd1, 8'h20);
      wait_idle();
      bus_op(1'b0, 1'b0, 8'h0F);
      chk("err_sticky", 32'(err), 1);
      chk("disp_all", 32'({display_on, cursor_on, blink_on}), 32'h7);
      wait_idle();

      bus_op(1'b0, 1'b0, 8'h01);
      repeat (10) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 0);
      chk("arst_ac", 32'(ac), 0);
      chk("arst_err", 32'(err), 0);
      chk("arst_oe", 32'(DB_oe), 0);
      chk("arst_dbout", 32'(DB_out), 0);
      chk("arst_rd", 32'(rd_data), 0);
      chk("arst_disp", 32'({display_on, cursor_on, blink_on}), 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("post_busy", 32'(busy), 0);
      bus_op(1'b1, 1'b0, 8'h61);
      chk("post_ac", 32'(ac), 32'h01);
      rd_chk("post_m0", 5'd0, 8'h61);
      rd_chk("post_m1", 5'd1, 8'h20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
